uart_rx_tx: RTL and testbench

UART_RX_TX -- requirements
Module: uart_rx_tx

---
 rtl/uart_rx_tx.sv | 192 +++++++++++++++++++
 tb/tb_uart_rx_tx.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_tx.sv
// rtl/uart_rx_tx.sv - 8N1 UART receiver and transmitter with independent FSMs
`timescale 1ns/1ps
module uart_rx_tx #(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_RX_Serial,
  output logic [7:0] o_RX_Byte,
  output logic       o_RX_DV,
  input  logic       i_TX_DV,
  input  logic [7:0] i_TX_Byte,
  output logic       o_TX_Serial,
  output logic       o_TX_Active,
  output logic       o_TX_Done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_CLEANUP} state_t;

  logic rx_meta, rx_sync;

  state_t          rx_state, rx_state_n;
  logic [CW-1:0]   rx_cnt, rx_cnt_n;
  logic [2:0]      rx_idx, rx_idx_n;
  logic [7:0]      rx_byte_n;
  logic            rx_dv_n;

  state_t          tx_state, tx_state_n;
  logic [CW-1:0]   tx_cnt, tx_cnt_n;
  logic [2:0]      tx_idx, tx_idx_n;
  logic [7:0]      tx_data, tx_data_n;
  logic            tx_serial_n, tx_active_n, tx_done_n;

  // Synchronizer idles high so reset never looks like a start bit
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= i_RX_Serial;
      rx_sync <= rx_meta;
    end
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      rx_state  <= S_IDLE;
      rx_cnt    <= '0;
      rx_idx    <= '0;
      o_RX_Byte <= 8'h00;
      o_RX_DV   <= 1'b0;
    end else begin
      rx_state  <= rx_state_n;
      rx_cnt    <= rx_cnt_n;
      rx_idx    <= rx_idx_n;
      o_RX_Byte <= rx_byte_n;
      o_RX_DV   <= rx_dv_n;
    end
  end

  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt;
    rx_idx_n   = rx_idx;
    rx_byte_n  = o_RX_Byte;
    rx_dv_n    = 1'b0;
    case (rx_state)
      S_IDLE: begin
        rx_cnt_n = '0;
        rx_idx_n = '0;
        if (!rx_sync) rx_state_n = S_START;
      end
      S_START: begin
        if (rx_cnt == HALF) begin
          rx_cnt_n   = '0;
          rx_state_n = rx_sync ? S_IDLE : S_DATA;
        end else begin
          rx_cnt_n = rx_cnt + CW'(1);
        end
      end
      S_DATA: begin
        if (rx_cnt < LAST) begin
          rx_cnt_n = rx_cnt + CW'(1);
        end else begin
          rx_cnt_n          = '0;
          rx_byte_n[rx_idx] = rx_sync;
          if (rx_idx == 3'd7) begin
            rx_idx_n   = '0;
            rx_state_n = S_STOP;
          end else begin
            rx_idx_n = rx_idx + 3'd1;
          end
        end
      end
      S_STOP: begin
        if (rx_cnt < LAST) begin
          rx_cnt_n = rx_cnt + CW'(1);
        end else begin
          rx_cnt_n   = '0;
          rx_dv_n    = 1'b1;
          rx_state_n = S_CLEANUP;
        end
      end
      S_CLEANUP: rx_state_n = S_IDLE;
      default:   rx_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      tx_state    <= S_IDLE;
      tx_cnt      <= '0;
      tx_idx      <= '0;
      tx_data     <= 8'h00;
      o_TX_Serial <= 1'b1;
      o_TX_Active <= 1'b0;
      o_TX_Done   <= 1'b0;
    end else begin
      tx_state    <= tx_state_n;
      tx_cnt      <= tx_cnt_n;
      tx_idx      <= tx_idx_n;
      tx_data     <= tx_data_n;
      o_TX_Serial <= tx_serial_n;
      o_TX_Active <= tx_active_n;
      o_TX_Done   <= tx_done_n;
    end
  end

  // Line level is registered, so every level shows one clock after its state
  always_comb begin
    tx_state_n  = tx_state;
    tx_cnt_n    = tx_cnt;
    tx_idx_n    = tx_idx;
    tx_data_n   = tx_data;
    tx_serial_n = 1'b1;
    tx_active_n = o_TX_Active;
    tx_done_n   = 1'b0;
    case (tx_state)
      S_IDLE: begin
        tx_cnt_n    = '0;
        tx_idx_n    = '0;
        tx_active_n = 1'b0;
        if (i_TX_DV) begin
          tx_data_n   = i_TX_Byte;
          tx_active_n = 1'b1;
          tx_state_n  = S_START;
        end
      end
      S_START: begin
        tx_serial_n = 1'b0;
        if (tx_cnt < LAST) begin
          tx_cnt_n = tx_cnt + CW'(1);
        end else begin
          tx_cnt_n   = '0;
          tx_state_n = S_DATA;
        end
      end
      S_DATA: begin
        tx_serial_n = tx_data[tx_idx];
        if (tx_cnt < LAST) begin
          tx_cnt_n = tx_cnt + CW'(1);
        end else begin
          tx_cnt_n = '0;
          if (tx_idx == 3'd7) begin
            tx_idx_n   = '0;
            tx_state_n = S_STOP;
          end else begin
            tx_idx_n = tx_idx + 3'd1;
          end
        end
      end
      S_STOP: begin
        tx_serial_n = 1'b1;
        if (tx_cnt < LAST) begin
          tx_cnt_n = tx_cnt + CW'(1);
        end else begin
          tx_cnt_n    = '0;
          tx_done_n   = 1'b1;
          tx_active_n = 1'b0;
          tx_state_n  = S_CLEANUP;
        end
      end
      S_CLEANUP: tx_state_n = S_IDLE;
      default:   tx_state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_rx_tx.sv
// tb/tb_uart_rx_tx.sv - directed self-checking bench for uart_rx_tx
`timescale 1ns/1ps
module tb_uart_rx_tx;

  localparam int CPB  = 217;
  localparam int NCAP = 2200;

  logic       i_Clock = 1'b0;
  logic       i_Reset;
  logic       rx_line;
  logic [7:0] o_RX_Byte;
  logic       o_RX_DV;
  logic       tx_dv, tx_dv_drv, echo_en;
  logic [7:0] tx_byte, tx_byte_drv;
  logic       o_TX_Serial, o_TX_Active, o_TX_Done;

  int total = 0;
  int bad   = 0;

  int dv_cnt   = 0;
  int done_cnt = 0;
  int cap_cnt  = 0;
  int tx_off   = -1;
  logic cap_arm;
  logic ser_d = 1'b1;
  logic samp_ser  [0:NCAP-1];
  logic samp_done [0:NCAP-1];
  logic samp_act  [0:NCAP-1];

  int d0, n0, c0;

  assign tx_dv   = echo_en ? o_RX_DV   : tx_dv_drv;
  assign tx_byte = echo_en ? o_RX_Byte : tx_byte_drv;

  uart_rx_tx #(.CLKS_PER_BIT(CPB)) dut (
    .i_Clock     (i_Clock),
    .i_Reset     (i_Reset),
    .i_RX_Serial (rx_line),
    .o_RX_Byte   (o_RX_Byte),
    .o_RX_DV     (o_RX_DV),
    .i_TX_DV     (tx_dv),
    .i_TX_Byte   (tx_byte),
    .o_TX_Serial (o_TX_Serial),
    .o_TX_Active (o_TX_Active),
    .o_TX_Done   (o_TX_Done)
  );

  always #20 i_Clock = ~i_Clock;

  // Captures one TX frame, offset 0 being the first low sample of the start bit
  always @(negedge i_Clock) begin
    ser_d <= o_TX_Serial;
    if (o_RX_DV)   dv_cnt   <= dv_cnt + 1;
    if (o_TX_Done) done_cnt <= done_cnt + 1;
    if (i_Reset) begin
      tx_off <= -1;
    end else if (tx_off < 0) begin
      if (cap_arm && ser_d && !o_TX_Serial) begin
        samp_ser[0]  <= o_TX_Serial;
        samp_done[0] <= o_TX_Done;
        samp_act[0]  <= o_TX_Active;
        tx_off <= 1;
      end
    end else if (tx_off < NCAP) begin
      samp_ser[tx_off]  <= o_TX_Serial;
      samp_done[tx_off] <= o_TX_Done;
      samp_act[tx_off]  <= o_TX_Active;
      tx_off <= tx_off + 1;
    end else begin
      tx_off  <= -1;
      cap_cnt <= cap_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic uart_send(input logic [7:0] b, input int bit_ns, input int start_ns);
    rx_line = 1'b0;
    #(start_ns);
    for (int i = 0; i < 8; i++) begin
      rx_line = b[i];
      #(bit_ns);
    end
    rx_line = 1'b1;
    #(bit_ns);
  endtask

  task automatic wait_cap(input int c_start);
    for (int i = 0; i < 6000 && cap_cnt == c_start; i++) @(negedge i_Clock);
    chk("capture_timeout", (cap_cnt != c_start), 1);
  endtask

  task automatic check_frame(input string tag, input logic [7:0] b);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("%s_lvl%0d_head", tag, k), samp_ser[CPB*k], f[k]);
      chk($sformatf("%s_lvl%0d_tail", tag, k), samp_ser[CPB*k + CPB - 1], f[k]);
    end
    chk($sformatf("%s_done_before", tag), samp_done[10*CPB - 2], 0);
    chk($sformatf("%s_done_at_end", tag), samp_done[10*CPB - 1], 1);
    chk($sformatf("%s_done_after", tag),  samp_done[10*CPB], 0);
    chk($sformatf("%s_active_last", tag), samp_act[10*CPB - 2], 1);
    chk($sformatf("%s_active_drop", tag), samp_act[10*CPB - 1], 0);
  endtask

  initial begin
    i_Reset = 1'b1;
    rx_line = 1'b1;
    tx_dv_drv = 1'b0;
    tx_byte_drv = 8'h00;
    echo_en = 1'b0;
    cap_arm = 1'b0;
    repeat (3) @(negedge i_Clock);
    chk("rst_rx_byte", o_RX_Byte, 8'h00);
    chk("rst_rx_dv", o_RX_DV, 0);
    chk("rst_tx_serial", o_TX_Serial, 1);
    chk("rst_tx_active", o_TX_Active, 0);
    chk("rst_tx_done", o_TX_Done, 0);
    i_Reset = 1'b0;
    repeat (10) @(negedge i_Clock);
    chk("idle_tx_serial", o_TX_Serial, 1);

    // 0x37 with fast bits and a stretched start bit, echoed back out
    echo_en = 1'b1;
    cap_arm = 1'b1;
    d0 = dv_cnt; n0 = done_cnt; c0 = cap_cnt;
    uart_send(8'h37, 8600, 9600);
    @(posedge i_Clock); #1;
    chk("rx_byte_37", o_RX_Byte, 8'h37);
    chk("rx_dv_count_37", dv_cnt - d0, 1);
    wait_cap(c0);
    cap_arm = 1'b0;
    echo_en = 1'b0;
    check_frame("echo37", 8'h37);
    repeat (20) @(negedge i_Clock);
    chk("echo_done_count", done_cnt - n0, 1);

    d0 = dv_cnt;
    uart_send(8'h56, 8600, 9600);
    @(posedge i_Clock); #1;
    chk("rx_byte_56", o_RX_Byte, 8'h56);
    chk("rx_dv_count_56", dv_cnt - d0, 1);

    // 50-clock low glitch on an idle line
    d0 = dv_cnt;
    @(negedge i_Clock);
    rx_line = 1'b0;
    repeat (50) @(negedge i_Clock);
    rx_line = 1'b1;
    repeat (3 * CPB) @(negedge i_Clock);
    chk("glitch_no_dv", dv_cnt - d0, 0);
    chk("glitch_byte_held", o_RX_Byte, 8'h56);

    // Second request mid-frame must be ignored
    n0 = done_cnt; c0 = cap_cnt;
    cap_arm = 1'b1;
    tx_byte_drv = 8'hA5;
    tx_dv_drv = 1'b1;
    @(negedge i_Clock);
    tx_dv_drv = 1'b0;
    repeat (1000) @(negedge i_Clock);
    chk("midframe_active", o_TX_Active, 1);
    tx_byte_drv = 8'h5A;
    tx_dv_drv = 1'b1;
    @(negedge i_Clock);
    tx_dv_drv = 1'b0;
    wait_cap(c0);
    cap_arm = 1'b0;
    check_frame("txA5", 8'hA5);
    repeat (3000) @(negedge i_Clock);
    chk("ignore_done_count", done_cnt - n0, 1);
    chk("ignore_serial_idle", o_TX_Serial, 1);
    chk("ignore_active_idle", o_TX_Active, 0);

    // Reset during RX bit 4 and TX bit 4
    d0 = dv_cnt; n0 = done_cnt;
    tx_byte_drv = 8'h00;
    @(negedge i_Clock);
    tx_dv_drv = 1'b1;
    rx_line = 1'b0;
    @(negedge i_Clock);
    tx_dv_drv = 1'b0;
    #(5 * 8680 + 4000 - 40);
    chk("pre_rst_tx_serial", o_TX_Serial, 0);
    chk("pre_rst_tx_active", o_TX_Active, 1);
    i_Reset = 1'b1;
    rx_line = 1'b1;
    #1;
    chk("mid_rst_tx_serial", o_TX_Serial, 1);
    chk("mid_rst_tx_active", o_TX_Active, 0);
    chk("mid_rst_tx_done", o_TX_Done, 0);
    chk("mid_rst_rx_dv", o_RX_DV, 0);
    chk("mid_rst_rx_byte", o_RX_Byte, 8'h00);
    repeat (5) @(negedge i_Clock);
    i_Reset = 1'b0;
    repeat (3000) @(negedge i_Clock);
    chk("post_rst_no_dv", dv_cnt - d0, 0);
    chk("post_rst_no_done", done_cnt - n0, 0);
    chk("post_rst_serial", o_TX_Serial, 1);

    d0 = dv_cnt;
    uart_send(8'hC3, 8680, 8680);
    @(posedge i_Clock); #1;
    chk("rx_byte_c3", o_RX_Byte, 8'hC3);
    chk("rx_dv_count_c3", dv_cnt - d0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
